servio_loader: RTL and testbench

SERVIO_LOADER -- requirements
Module: servio_loader

---
 rtl/servio_loader.sv | 146 ++++++++++++++
 tb/tb_servio_loader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servio_loader.sv
`default_nettype none
// ============================================================================
// Module   : servio_loader
// Brief    : Parses framed program images from the host byte link into the
//            program ROM. Holds the cores stopped until a frame checks good.
// Revision : 1.0 - initial release
// ============================================================================
module servio_loader #(
    parameter int DATA_DEPTH = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    asi_in_data,
    input  logic                          asi_in_valid,
    output logic                          asi_in_ready,
    output logic [$clog2(DATA_DEPTH)-1:0] avm_m0_address,
    output logic                          avm_m0_write,
    output logic [7:0]                    avm_m0_writedata,
    output logic                          o_stop,
    output logic                          o_done,
    output logic                          o_error
);

    localparam int              AW          = $clog2(DATA_DEPTH);
    localparam logic [AW-1:0]   c_last_addr = AW'(DATA_DEPTH - 1);
    localparam logic [7:0]      c_sync      = 8'h55;

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_addr_h = 3'd1;
    localparam logic [2:0] c_addr_l = 3'd2;
    localparam logic [2:0] c_len_h  = 3'd3;
    localparam logic [2:0] c_len_l  = 3'd4;
    localparam logic [2:0] c_data   = 3'd5;
    localparam logic [2:0] c_csum   = 3'd6;
    localparam logic [2:0] c_fin    = 3'd7;

    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic          w_xfer;
    logic [7:0]    r_addr_h;
    logic [15:0]   r_len;
    logic [15:0]   r_count;
    logic [15:0]   w_len_full;
    logic [15:0]   w_count_inc;
    logic [AW-1:0] w_start_addr;
    logic [AW-1:0] r_ptr;
    logic [7:0]    r_csum;
    logic [AW-1:0] r_address;
    logic [7:0]    r_wdata;
    logic          r_write;
    logic          r_done;
    logic          r_error;
    logic          r_stop;

    // Ready is combinational so a byte can be taken in the very first cycle after reset.
    assign asi_in_ready = ~reset & (r_state != c_fin);
    assign w_xfer       = asi_in_valid & asi_in_ready;
    assign w_len_full   = {r_len[15:8], asi_in_data};
    assign w_count_inc  = r_count + 16'd1;
    assign w_start_addr = AW'({r_addr_h, asi_in_data});

    assign avm_m0_address   = r_address;
    assign avm_m0_write     = r_write;
    assign avm_m0_writedata = r_wdata;
    assign o_stop           = r_stop;
    assign o_done           = r_done;
    assign o_error          = r_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:   if (w_xfer && asi_in_data == c_sync) w_state_next = c_addr_h;
            c_addr_h: if (w_xfer) w_state_next = c_addr_l;
            c_addr_l: if (w_xfer) w_state_next = c_len_h;
            c_len_h:  if (w_xfer) w_state_next = c_len_l;
            c_len_l:  if (w_xfer) w_state_next = (w_len_full == 16'd0) ? c_csum : c_data;
            c_data:   if (w_xfer && w_count_inc == r_len) w_state_next = c_csum;
            c_csum:   if (w_xfer) w_state_next = c_fin;
            c_fin:    w_state_next = c_idle;
            default:  w_state_next = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_h  <= 8'd0;
            r_len     <= 16'd0;
            r_count   <= 16'd0;
            r_ptr     <= '0;
            r_csum    <= 8'd0;
            r_address <= '0;
            r_wdata   <= 8'd0;
            r_write   <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_stop    <= 1'b1;
        end else begin
            r_write <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (w_xfer) begin
                case (r_state)
                    c_idle: begin
                        if (asi_in_data == c_sync) begin
                            r_stop  <= 1'b1;
                            r_csum  <= 8'd0;
                            r_count <= 16'd0;
                        end
                    end
                    c_addr_h: r_addr_h    <= asi_in_data;
                    c_addr_l: r_ptr       <= w_start_addr;
                    c_len_h:  r_len[15:8] <= asi_in_data;
                    c_len_l:  r_len[7:0]  <= asi_in_data;
                    c_data: begin
                        r_write   <= 1'b1;
                        r_address <= r_ptr;
                        r_wdata   <= asi_in_data;
                        // Explicit wrap keeps non-power-of-two depths inside the ROM.
                        r_ptr     <= (r_ptr == c_last_addr) ? '0 : r_ptr + AW'(1);
                        r_csum    <= r_csum ^ asi_in_data;
                        r_count   <= w_count_inc;
                    end
                    c_csum: begin
                        if (asi_in_data == r_csum) begin
                            r_done <= 1'b1;
                            r_stop <= 1'b0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_servio_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_servio_loader
// Brief    : Self-checking bench for servio_loader: vector table, directed
//            timing/reset sequences and randomized frames against a parser model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_servio_loader;

    localparam int DATA_DEPTH = 1024;
    localparam int AW         = $clog2(DATA_DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    asi_in_data;
    logic          asi_in_valid;
    logic          asi_in_ready;
    logic [AW-1:0] avm_m0_address;
    logic          avm_m0_write;
    logic [7:0]    avm_m0_writedata;
    logic          o_stop;
    logic          o_done;
    logic          o_error;

    servio_loader #(.DATA_DEPTH(DATA_DEPTH)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .asi_in_data      (asi_in_data),
        .asi_in_valid     (asi_in_valid),
        .asi_in_ready     (asi_in_ready),
        .avm_m0_address   (avm_m0_address),
        .avm_m0_write     (avm_m0_write),
        .avm_m0_writedata (avm_m0_writedata),
        .o_stop           (o_stop),
        .o_done           (o_done),
        .o_error          (o_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         mon_addr[$];
    int         mon_data[$];
    int         mon_done = 0;
    int         mon_err  = 0;

    logic [7:0] stim[$];
    int         m_addr[$];
    int         m_data[$];
    int         m_nd;
    int         m_ne;
    logic       m_stop;

    typedef struct packed {
        logic [0:11][7:0] b;
        int               n;
        int               nw;
        logic [0:3][15:0] wa;
        logic [0:3][7:0]  wd;
        int               nd;
        int               ne;
        logic             stop;
        logic             gaps;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (avm_m0_write) begin
            mon_addr.push_back(int'(avm_m0_address));
            mon_data.push_back(int'(avm_m0_writedata));
        end
        if (o_done) mon_done++;
        if (o_error) mon_err++;
        if (o_done || o_error) check("pulse_exclusive", {31'd0, o_done & o_error}, 32'd0);
    end

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        mon_done = 0;
        mon_err  = 0;
    endtask

    task automatic idle(input int n);
        asi_in_valid = 1'b0;
        repeat (n) begin
            asi_in_data = 8'($urandom);
            @(negedge clk);
        end
    endtask

    // Presents one byte at a negedge and returns at the negedge after it was taken.
    task automatic put_byte(input logic [7:0] d);
        int guard = 0;
        asi_in_data  = d;
        asi_in_valid = 1'b1;
        while (!asi_in_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (!asi_in_ready) check("ready_timeout", {31'd0, asi_in_ready}, 32'd1);
        @(negedge clk);
        asi_in_valid = 1'b0;
    endtask

    task automatic send_stim(input logic gaps);
        for (int i = 0; i < stim.size(); i++) begin
            if (gaps) idle($urandom_range(0, 2));
            put_byte(stim[i]);
        end
    endtask

    // Frame-level reference: scan for sync, read header, log payload writes, judge checksum.
    task automatic model_run();
        int         i;
        int         a;
        int         len;
        logic [7:0] x;
        i = 0;
        m_addr.delete();
        m_data.delete();
        m_nd   = 0;
        m_ne   = 0;
        m_stop = 1'b1;
        while (i < stim.size()) begin
            if (stim[i] != 8'h55) begin
                i++;
                continue;
            end
            m_stop = 1'b1;
            if (i + 4 >= stim.size()) break;
            a   = int'({stim[i+1], stim[i+2]}) % DATA_DEPTH;
            len = int'({stim[i+3], stim[i+4]});
            x   = 8'd0;
            i   = i + 5;
            for (int k = 0; k < len && i < stim.size(); k++) begin
                m_addr.push_back(a);
                m_data.push_back(int'(stim[i]));
                x = x ^ stim[i];
                a = (a + 1) % DATA_DEPTH;
                i++;
            end
            if (i >= stim.size()) break;
            if (stim[i] == x) begin
                m_nd++;
                m_stop = 1'b0;
            end else begin
                m_ne++;
            end
            i++;
        end
    endtask

    task automatic build_random(input int frames);
        logic [7:0] x;
        logic [7:0] g;
        logic [7:0] p;
        int         len;
        stim.delete();
        for (int f = 0; f < frames; f++) begin
            repeat ($urandom_range(0, 3)) begin
                g = 8'($urandom);
                if (g == 8'h55) g = 8'h54;
                stim.push_back(g);
            end
            len = $urandom_range(0, 12);
            stim.push_back(8'h55);
            stim.push_back(8'($urandom));
            stim.push_back(8'($urandom));
            stim.push_back(8'h00);
            stim.push_back(8'(len));
            x = 8'd0;
            for (int k = 0; k < len; k++) begin
                p = 8'($urandom);
                stim.push_back(p);
                x = x ^ p;
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'(($urandom_range(1, 255)));
            stim.push_back(x);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;

        vt[0] = '{b: {8'h55,8'h00,8'h10,8'h00,8'h03,8'hAA,8'hBB,8'hCC,8'hDD,8'h00,8'h00,8'h00},
                  n: 9, nw: 3, wa: {16'h010,16'h011,16'h012,16'h000}, wd: {8'hAA,8'hBB,8'hCC,8'h00},
                  nd: 1, ne: 0, stop: 1'b0, gaps: 1'b0};
        vt[1] = '{b: {8'h55,8'h00,8'h10,8'h00,8'h03,8'hAA,8'hBB,8'hCC,8'h00,8'h00,8'h00,8'h00},
                  n: 9, nw: 3, wa: {16'h010,16'h011,16'h012,16'h000}, wd: {8'hAA,8'hBB,8'hCC,8'h00},
                  nd: 0, ne: 1, stop: 1'b1, gaps: 1'b0};
        vt[2] = '{b: {8'h55,8'h00,8'h10,8'h00,8'h03,8'hAA,8'hBB,8'hCC,8'hDD,8'h00,8'h00,8'h00},
                  n: 9, nw: 3, wa: {16'h010,16'h011,16'h012,16'h000}, wd: {8'hAA,8'hBB,8'hCC,8'h00},
                  nd: 1, ne: 0, stop: 1'b0, gaps: 1'b1};
        vt[3] = '{b: {8'h55,8'h03,8'hFE,8'h00,8'h04,8'h01,8'h02,8'h03,8'h04,8'h04,8'h00,8'h00},
                  n: 10, nw: 4, wa: {16'h3FE,16'h3FF,16'h000,16'h001}, wd: {8'h01,8'h02,8'h03,8'h04},
                  nd: 1, ne: 0, stop: 1'b0, gaps: 1'b0};
        vt[4] = '{b: {8'h00,8'hFF,8'h55,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                  n: 8, nw: 0, wa: {16'h000,16'h000,16'h000,16'h000}, wd: {8'h00,8'h00,8'h00,8'h00},
                  nd: 1, ne: 0, stop: 1'b0, gaps: 1'b0};
        vt[5] = '{b: {8'h55,8'h00,8'h20,8'h00,8'h02,8'h55,8'h55,8'h00,8'h00,8'h00,8'h00,8'h00},
                  n: 8, nw: 2, wa: {16'h020,16'h021,16'h000,16'h000}, wd: {8'h55,8'h55,8'h00,8'h00},
                  nd: 1, ne: 0, stop: 1'b0, gaps: 1'b1};
        vt[6] = '{b: {8'h55,8'h12,8'h34,8'h00,8'h00,8'h07,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                  n: 6, nw: 0, wa: {16'h000,16'h000,16'h000,16'h000}, wd: {8'h00,8'h00,8'h00,8'h00},
                  nd: 0, ne: 1, stop: 1'b1, gaps: 1'b0};

        reset        = 1'b1;
        asi_in_valid = 1'b1;
        asi_in_data  = 8'h55;
        repeat (3) @(negedge clk);
        check("rst_ready",   {31'd0, asi_in_ready},     32'd0);
        check("rst_write",   {31'd0, avm_m0_write},     32'd0);
        check("rst_address", 32'(avm_m0_address),       32'd0);
        check("rst_wdata",   {24'd0, avm_m0_writedata}, 32'd0);
        check("rst_done",    {31'd0, o_done},           32'd0);
        check("rst_error",   {31'd0, o_error},          32'd0);
        check("rst_stop",    {31'd0, o_stop},           32'd1);

        // Back-to-back frame starting in the first cycle out of reset, with cycle-exact checks.
        asi_in_valid = 1'b0;
        reset        = 1'b0;
        c0           = cyc;
        #1;
        check("ready_after_rst", {31'd0, asi_in_ready}, 32'd1);
        put_byte(8'h55);
        put_byte(8'h00);
        put_byte(8'h10);
        put_byte(8'h00);
        put_byte(8'h03);
        put_byte(8'hAA);
        check("first_write_latency", 32'(cyc - c0), 32'd6);
        check("w0_strobe", {31'd0, avm_m0_write},   32'd1);
        check("w0_addr",   32'(avm_m0_address),     32'h010);
        check("w0_data",   {24'd0, avm_m0_writedata}, 32'hAA);
        put_byte(8'hBB);
        check("w1_strobe", {31'd0, avm_m0_write},   32'd1);
        check("w1_addr",   32'(avm_m0_address),     32'h011);
        put_byte(8'hCC);
        check("w2_strobe", {31'd0, avm_m0_write},   32'd1);
        check("w2_addr",   32'(avm_m0_address),     32'h012);
        check("stop_before_csum", {31'd0, o_stop},  32'd1);
        put_byte(8'hDD);
        check("csum_no_write", {31'd0, avm_m0_write}, 32'd0);
        check("done_pulse",    {31'd0, o_done},       32'd1);
        check("no_error",      {31'd0, o_error},      32'd0);
        check("stop_cleared",  {31'd0, o_stop},       32'd0);
        check("fin_ready_low", {31'd0, asi_in_ready}, 32'd0);
        @(negedge clk);
        check("done_one_cycle",  {31'd0, o_done},       32'd0);
        check("ready_after_fin", {31'd0, asi_in_ready}, 32'd1);
        idle(2);
        check("timing_nwrites", 32'(mon_addr.size()), 32'd3);
        clear_mon();

        for (int v = 0; v < 7; v++) begin
            stim.delete();
            for (int i = 0; i < vt[v].n; i++) stim.push_back(vt[v].b[i]);
            send_stim(vt[v].gaps);
            idle(3);
            check($sformatf("vec%0d_nwrites", v), 32'(mon_addr.size()), 32'(vt[v].nw));
            for (int k = 0; k < vt[v].nw && k < mon_addr.size(); k++) begin
                check($sformatf("vec%0d_addr%0d", v, k), 32'(mon_addr[k]), 32'(vt[v].wa[k]));
                check($sformatf("vec%0d_data%0d", v, k), 32'(mon_data[k]), 32'(vt[v].wd[k]));
            end
            check($sformatf("vec%0d_done", v),  32'(mon_done), 32'(vt[v].nd));
            check($sformatf("vec%0d_error", v), 32'(mon_err),  32'(vt[v].ne));
            check($sformatf("vec%0d_stop", v),  {31'd0, o_stop}, {31'd0, vt[v].stop});
            clear_mon();
        end

        // Reset lands right after the second payload byte.
        stim = '{8'h55, 8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'hBB};
        send_stim(1'b0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(4);
        check("midrst_nwrites", 32'(mon_addr.size()), 32'd2);
        check("midrst_done",    32'(mon_done),        32'd0);
        check("midrst_error",   32'(mon_err),         32'd0);
        check("midrst_stop",    {31'd0, o_stop},      32'd1);
        clear_mon();
        stim = '{8'h55, 8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_stim(1'b0);
        idle(3);
        check("postrst_nwrites", 32'(mon_addr.size()), 32'd3);
        if (mon_data.size() == 3) check("postrst_data2", 32'(mon_data[2]), 32'hCC);
        check("postrst_done", 32'(mon_done),   32'd1);
        check("postrst_stop", {31'd0, o_stop}, 32'd0);
        clear_mon();

        for (int r = 0; r < 4; r++) begin
            build_random(8);
            model_run();
            send_stim(1'b1);
            idle(4);
            check($sformatf("rnd%0d_nwrites", r), 32'(mon_addr.size()), 32'(m_addr.size()));
            for (int k = 0; k < m_addr.size() && k < mon_addr.size(); k++) begin
                check($sformatf("rnd%0d_write%0d", r, k),
                      32'((mon_addr[k] << 8) | mon_data[k]), 32'((m_addr[k] << 8) | m_data[k]));
            end
            check($sformatf("rnd%0d_done", r),  32'(mon_done),   32'(m_nd));
            check($sformatf("rnd%0d_error", r), 32'(mon_err),    32'(m_ne));
            check($sformatf("rnd%0d_stop", r),  {31'd0, o_stop}, {31'd0, m_stop});
            clear_mon();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
